fetch_unit: RTL and testbench

Instruction fetch front end of the single-cycle/pipelined core. It owns the program counter, drives the word address into the instruction memory, and captures each returned instruction word together with its PC into a small FIFO. Decode consumes the FIFO through a valid/ready handshake. A redirect port (branch/jump) flushes the FIFO and restarts fetch at a new PC.

---
 rtl/fetch_unit.sv | 133 +++++++++++++
 tb/tb_fetch_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, captures {pc, instruction} into a small FIFO for decode.
// Optional enqueue counter on port fetch_count is built when FETCH_PERF_CNT_EN is defined.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] program_counter,
  input  logic [31:0] instruction_in,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      buf_instr_q [DEPTH];
  logic [31:0]      buf_instr_d [DEPTH];
  logic [31:0]      buf_pc_q    [DEPTH];
  logic [31:0]      buf_pc_d    [DEPTH];

  logic valid_s;
  logic deq_s;
  logic full_s;
  logic enq_s;
  logic unused_redirect_lsb_s;

  assign unused_redirect_lsb_s = ^redirect_pc[1:0];

  // Handshake decode; fullness is judged after a same-cycle dequeue so a full FIFO keeps streaming.
  always_comb begin
    valid_s = (count_q != {CNT_W{1'b0}});
    deq_s   = valid_s && instr_ready && !redirect_valid;
    full_s  = (count_q == CNT_FULL) && !deq_s;
    enq_s   = !full_s && !redirect_valid;
  end

  // Next-state for PC, pointers, count and buffer contents; a redirect overrides everything.
  always_comb begin
    pc_d        = pc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    if (redirect_valid) begin
      pc_d     = {redirect_pc[31:2], 2'b00};
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (enq_s) begin
        buf_instr_d[wr_ptr_q] = instruction_in;
        buf_pc_d[wr_ptr_q]    = pc_q;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        pc_d                  = pc_q + 32'd4;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (deq_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CNT_W'(enq_s) - CNT_W'(deq_s);
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Buffer payload needs no reset: it is only observed through a non-zero count.
  always_ff @(posedge clk) begin
    buf_instr_q <= buf_instr_d;
    buf_pc_q    <= buf_pc_d;
  end

  assign program_counter = pc_q;
  assign instr_valid     = valid_s;
  assign instr_out       = valid_s ? buf_instr_q[rd_ptr_q] : 32'h0000_0000;
  assign instr_pc        = valid_s ? buf_pc_q[rd_ptr_q]    : 32'h0000_0000;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;

  // Enqueue events since reset; redirects do not clear it.
  always_comb begin
    if (enq_s) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end else begin
      fetch_count_d = fetch_count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q <= 32'd0;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model feeds a scoreboard checked by a negedge monitor.
module tb_fetch_unit;
  localparam int          DEPTH     = 2;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] RESET_PC2 = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        reset, instr_ready, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] program_counter, instruction_in, instr_out, instr_pc;
  logic        instr_valid;
  logic [31:0] pc2, in2, out2, ipc2;
  logic        valid2;
  logic [31:0] imem [256];
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count, fetch_count2;
`endif

  always #5 clk = ~clk;

  assign instruction_in = imem[program_counter[9:2]];
  assign in2            = imem[pc2[9:2]];

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .program_counter(program_counter),
    .instruction_in(instruction_in), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_out(instr_out), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fetch_count)
`endif
  );

  fetch_unit #(.RESET_PC(RESET_PC2), .DEPTH(DEPTH)) dut2 (
    .clk(clk), .reset(reset), .program_counter(pc2),
    .instruction_in(in2), .instr_valid(valid2),
    .instr_ready(instr_ready), .instr_out(out2), .instr_pc(ipc2),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fetch_count2)
`endif
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      sb[$];
  int          m_cnt;
  logic [31:0] m_pc;
  logic [31:0] m_fc;
  bit          checking = 1'b0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO occupancy and PC from the fetch rules; every fetched word goes to the scoreboard.
  always @(posedge clk) begin
    entry_t e;
    if (reset) begin
      sb.delete();
      m_cnt = 0;
      m_pc  = RESET_PC;
      m_fc  = 32'd0;
    end else if (redirect_valid) begin
      sb.delete();
      m_cnt = 0;
      m_pc  = {redirect_pc[31:2], 2'b00};
    end else begin
      if (m_cnt > 0 && instr_ready) m_cnt--;
      if (m_cnt < DEPTH) begin
        e.pc    = m_pc;
        e.instr = imem[m_pc[9:2]];
        sb.push_back(e);
        m_cnt++;
        m_pc = m_pc + 32'd4;
        m_fc = m_fc + 32'd1;
      end
    end
  end

  // Monitor: compares the DUT's presented head against the scoreboard and pops on each accepted handshake.
  always @(negedge clk) begin
    if (checking) begin
      chk("program_counter", program_counter, m_pc);
      chk("instr_valid", 32'(instr_valid), 32'(sb.size() != 0));
      if (instr_valid && sb.size() != 0) begin
        chk("head_instr", instr_out, sb[0].instr);
        chk("head_pc", instr_pc, sb[0].pc);
        if (instr_ready && !redirect_valid && !reset) void'(sb.pop_front());
      end else if (!instr_valid) begin
        chk("idle_instr_out", instr_out, 32'h0);
        chk("idle_instr_pc", instr_pc, 32'h0);
      end
`ifdef FETCH_PERF_CNT_EN
      chk("fetch_count", fetch_count, m_fc);
`endif
    end
  end

  task automatic step(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
    reset          = r;
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] t1_words [4];

  initial begin
    reset          = 1'b1;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    for (int i = 0; i < 256; i++) imem[i] = 32'h1000_0000 | 32'(i);
    t1_words[0] = 32'h0000_4430;
    t1_words[1] = 32'h0000_8610;
    t1_words[2] = 32'h0000_0431;
    t1_words[3] = 32'h0000_8610;
    for (int i = 0; i < 4; i++) imem[i] = t1_words[i];
    @(posedge clk);
    #1;
    checking = 1'b1;

    // Reset state and straight-line fetch stream.
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("reset_pc", program_counter, 32'h0);
    chk("reset_valid", 32'(instr_valid), 32'h0);
    chk("reset_out", instr_out, 32'h0);
    chk("reset_ipc", instr_pc, 32'h0);
    chk("reset_pc2", pc2, RESET_PC2);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      chk("stream_valid", 32'(instr_valid), 32'h1);
      chk("stream_out", instr_out, t1_words[k]);
      chk("stream_pc", instr_pc, 32'(4 * k));
    end

    // Back-pressure from reset: FIFO fills, PC holds, head stable, then resumes without skip.
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("stall_pc", program_counter, 32'h8);
    chk("stall_out", instr_out, 32'h0000_4430);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("resume_out", instr_out, 32'h0000_8610);
    chk("resume_pc", instr_pc, 32'h4);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("resume_out2", instr_out, 32'h0000_0431);

    // Redirect to an unaligned target while full with ready high: no dequeue, FIFO empty next cycle.
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("full_pc", program_counter, 32'h8);
    step(1'b0, 1'b1, 1'b1, 32'h0000_000B);
    chk("redir_valid", 32'(instr_valid), 32'h0);
    chk("redir_pc", program_counter, 32'h8);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("redir_head_pc", instr_pc, 32'h8);
    chk("redir_head_out", instr_out, 32'h0000_0431);

    // PC wrap from a high reset value on the second instance.
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("wrap_pc0", ipc2, 32'hFFFF_FFF8);
    chk("wrap_out0", out2, 32'h1000_00FE);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("wrap_pc1", ipc2, 32'hFFFF_FFFC);
    chk("wrap_out1", out2, 32'h1000_00FF);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("wrap_pc2", ipc2, 32'h0000_0000);
    chk("wrap_out2", out2, 32'h0000_4430);

`ifdef FETCH_PERF_CNT_EN
    step(1'b1, 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("perf_10", fetch_count, 32'd10);
    step(1'b0, 1'b1, 1'b1, 32'h40);
    chk("perf_redirect", fetch_count, 32'd10);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("perf_12", fetch_count, 32'd12);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("perf_reset", fetch_count, 32'd0);
`endif

    // Randomized traffic: back-pressure, redirects (some near the top of memory) and mid-stream resets.
    for (int i = 0; i < 256; i++) imem[i] = $urandom();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int n = 0; n < 3000; n++) begin
      logic        r, rdy, rv;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 99) == 0);
      rv  = ($urandom_range(0, 99) < 8);
      rdy = ($urandom_range(0, 99) < 65);
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else rpc = 32'($urandom_range(0, 1023));
      step(r, rdy, rv, rpc);
    end

    step(1'b0, 1'b0, 1'b0, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
